// File: rtl/muldiv_unit_if.sv
// Request/writeback bundle between the issue stage and the multi-cycle multiply/divide unit.
// The master drives the request side; the unit drives status and the register-file writeback.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_reg;
    logic        busy;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic        done;

    modport master (
        output start, op, operand_a, operand_b, dest_reg,
        input  busy, RegWrite, Write_register, Write_data, done
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_reg,
        output busy, RegWrite, Write_register, Write_data, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Unsigned 32-bit MULU/MULHU/DIVU/REMU, radix-2, 32 iterations + 1 writeback cycle (div-by-zero may skip).
// No queueing: start is only taken in IDLE, busy stays high until the writeback cycle has retired.
module muldiv_unit #(
    parameter bit DIV0_FAST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  dest_q, dest_d;
    logic [63:0] acc_q, acc_d;

    logic        accept;
    logic        last_iter;
    logic        div0_skip;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    logic        busy_c;
    logic        done_c;
    logic        regwrite_c;
    logic [4:0]  wreg_c;
    logic [31:0] wdata_c;

    assign accept    = (state_q == IDLE) && bus.start;
    assign last_iter = (cnt_q == 6'd31);
    assign div0_skip = DIV0_FAST && (b_q == 32'd0);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend/quotient}; the remainder stays below the
    // divisor, so bit 32 of the difference is a reliable borrow flag.
    assign div_rem  = {acc_q[63:32], acc_q[31]};
    assign div_diff = div_rem - {1'b0, b_q};
    assign div_next = div_diff[32] ? {div_rem[31:0],  acc_q[30:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = bus.op[1] ? DIV : MUL;
            MUL:  if (last_iter) state_d = WB;
            DIV:  if (div0_skip || last_iter) state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c     = (state_q != IDLE);
        done_c     = (state_q == WB);
        regwrite_c = (state_q == WB) && (dest_q != 5'd0);
        wreg_c     = (state_q == WB) ? dest_q : 5'd0;
        wdata_c    = 32'd0;
        if (state_q == WB) begin
            wdata_c = op_q[0] ? acc_q[63:32] : acc_q[31:0];
        end
    end

    assign bus.busy           = busy_c;
    assign bus.done           = done_c;
    assign bus.RegWrite       = regwrite_c;
    assign bus.Write_register = wreg_c;
    assign bus.Write_data     = wdata_c;

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        dest_d = dest_q;
        acc_d  = acc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d  = 6'd0;
                    op_d   = bus.op;
                    a_d    = bus.operand_a;
                    b_d    = bus.operand_b;
                    dest_d = bus.dest_reg;
                    acc_d  = bus.op[1] ? {32'd0, bus.operand_a} : {32'd0, bus.operand_b};
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
            end
            DIV: begin
                if (div0_skip) begin
                    // Same result the full iteration would reach: all-ones quotient, remainder = dividend.
                    acc_d = {acc_q[31:0], 32'hFFFF_FFFF};
                end else begin
                    acc_d = div_next;
                end
                cnt_d = cnt_q + 6'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 6'd0;
            op_q   <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            dest_q <= 5'd0;
            acc_q  <= 64'd0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            dest_q <= dest_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected writebacks queued at acceptance, checked on done.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit #(.DIV0_FAST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        rw;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic chk_busy_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int lat);
        exp_t e;
        e.dest    = d;
        e.data    = model(op, a, b);
        e.rw      = (d != 5'd0);
        e.acc_cyc = cyc;
        e.lat     = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input int lat);
        wait_idle();
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_reg  = d;
        @(posedge clk);
        #1;
        push(op, a, b, d, lat);
        chk("accept_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_regwrite"}, 32'(bus.RegWrite), 32'd0);
        chk({tag, "_wreg"}, 32'(bus.Write_register), 32'd0);
        chk({tag, "_wdata"}, bus.Write_data, 32'd0);
    endtask

    always @(negedge clk) begin
        if (chk_busy_next) begin
            chk("busy_after_wb", 32'(bus.busy), 32'd0);
            chk_busy_next = 1'b0;
        end
        if (bus.RegWrite && !bus.done) chk("regwrite_without_done", 32'd1, 32'd0);
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                chk("regwrite", 32'(bus.RegWrite), 32'(mon_e.rw));
                if (mon_e.rw) begin
                    chk("write_register", 32'(bus.Write_register), 32'(mon_e.dest));
                    chk("write_data", bus.Write_data, mon_e.data);
                end
                chk_busy_next = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rd;

        // Start held through reset must be ignored, then taken on the first released edge.
        bus.start     = 1'b1;
        bus.op        = 2'd0;
        bus.operand_a = 32'd7;
        bus.operand_b = 32'd6;
        bus.dest_reg  = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(2'd0, 32'd7, 32'd6, 5'd5, 32);
        chk("accept_after_reset", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_drain();

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32);
        issue(2'd2, 32'd100, 32'd7, 5'd3, 32);
        issue(2'd3, 32'd100, 32'd7, 5'd4, 32);
        issue(2'd2, 32'h1234_5678, 32'd0, 5'd5, 1);
        issue(2'd3, 32'h1234_5678, 32'd0, 5'd6, 1);
        issue(2'd0, 32'd3, 32'd5, 5'd0, 32);

        // Start pulsed at E10 with fresh operands must not disturb the running operation.
        issue(2'd0, 32'd1234, 32'd5678, 5'd9, 32);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = 2'd3;
        bus.operand_a = 32'hCAFE_0000;
        bus.operand_b = 32'd17;
        bus.dest_reg  = 5'd10;
        @(posedge clk);
        #1;
        chk("start_while_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_drain();

        // Start held high: second operation accepted at E34.
        wait_idle();
        bus.start     = 1'b1;
        bus.op        = 2'd2;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        bus.dest_reg  = 5'd11;
        @(posedge clk);
        #1;
        push(2'd2, 32'd1000, 32'd3, 5'd11, 32);
        bus.op        = 2'd0;
        bus.operand_a = 32'd77;
        bus.operand_b = 32'd16;
        bus.dest_reg  = 5'd12;
        repeat (34) @(posedge clk);
        #1;
        chk("held_start_reaccept", 32'(bus.busy), 32'd1);
        push(2'd0, 32'd77, 32'd16, 5'd12, 32);
        bus.start = 1'b0;
        wait_drain();

        // Reset at iteration 15 aborts with no writeback.
        wait_idle();
        bus.start     = 1'b1;
        bus.op        = 2'd0;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'd3;
        bus.dest_reg  = 5'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_outputs_zero("midop_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'd2, 32'hFFFF_FFFF, 32'd16, 5'd31, 32);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rd  = 5'($urandom_range(0, 31));
            issue(rop, ra, rb, rd, (rop[1] && rb == 32'd0) ? 1 : 32);
        end

        wait_drain();
        wait_idle();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
